// File: rtl/sequential_cla_subtract_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
// The master side presents operands and consumes results; the slave side is the subtractor.
interface sequential_cla_subtract_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;

    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, d, bo, ov, z
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, d, bo, ov, z
    );
endinterface

// File: rtl/sequential_cla_subtract.sv
// Digit-serial subtractor: d = a - b - bi computed as a + ~b + ~bi, one K-bit
// carry-lookahead digit per cycle, least-significant digit first.
module sequential_cla_subtract #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sequential_cla_subtract_if.slave    bus
);
    localparam int DIGITS = (K >= 1) ? N / K : 1;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (K < 1 || K > N || (N % K) != 0) begin : g_bad_params
            $fatal(1, "sequential_cla_subtract: K must divide N and satisfy 1 <= K <= N");
        end
    endgenerate

    // K-bit carry-lookahead slice: every carry is a flat sum of generate/propagate
    // products rather than a ripple chain. Returns {carry_out, sum}.
    function automatic logic [K:0] cla_slice(input logic [K-1:0] x,
                                             input logic [K-1:0] y,
                                             input logic         cin);
        logic [K-1:0] g;
        logic [K-1:0] p;
        logic [K:0]   c;
        logic         term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < K; i++) begin
            term = cin;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[K], p ^ c[K-1:0]};
    endfunction

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  nb_reg;
    logic [N-1:0]  d_reg;
    logic          bo_reg;
    logic          ov_reg;
    logic          z_reg;

    int            base;
    logic [K:0]    slice;
    logic [N-1:0]  d_next;
    logic          last_ov;

    // Current digit through the CLA slice, and the difference as it will look once it lands.
    always_comb begin
        base    = int'(cnt) * K;
        slice   = cla_slice(a_reg[base +: K], nb_reg[base +: K], carry);
        d_next  = d_reg;
        d_next[base +: K] = slice[K-1:0];
        // nb_reg holds ~b, so operand signs differ when the two stored MSBs are equal.
        last_ov = (a_reg[N-1] == nb_reg[N-1]) && (d_next[N-1] != a_reg[N-1]);
    end

    // Operand capture at accept; later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_reg  <= bus.a;
            nb_reg <= ~bus.b;
        end
    end

    // Control FSM, digit counter, carry chain and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            d_reg  <= '0;
            bo_reg <= 1'b0;
            ov_reg <= 1'b0;
            z_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        carry <= ~bus.bi;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    d_reg <= d_next;
                    carry <= slice[K];
                    if (cnt == LAST) begin
                        state  <= DONE;
                        bo_reg <= ~slice[K];
                        ov_reg <= last_ov;
                        z_reg  <= (d_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.d         = d_reg;
    assign bus.bo        = bo_reg;
    assign bus.ov        = ov_reg;
    assign bus.z         = z_reg;
endmodule

// File: tb/tb_sequential_cla_subtract.sv
// Directed bench for sequential_cla_subtract at K=8, K=32 and K=1 (N=32).
module tb_sequential_cla_subtract;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    sequential_cla_subtract_if #(.N(32)) bus8  ();
    sequential_cla_subtract_if #(.N(32)) bus32 ();
    sequential_cla_subtract_if #(.N(32)) bus1  ();

    sequential_cla_subtract #(.N(32), .K(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    sequential_cla_subtract #(.N(32), .K(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    sequential_cla_subtract #(.N(32), .K(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Present one operand set to the K=8 instance, scramble the inputs after
    // the accepting edge, and count edges until out_valid (bounded).
    task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic bi, output int lat);
        bus8.a = a; bus8.b = b; bus8.bi = bi; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0; bus8.a = 32'hFFFF_FFFF; bus8.b = 32'h0; bus8.bi = 1'b1;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release8;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
        checks++; if (bus8.d !== 32'h0) begin fails++; $display("FAIL reset_d: got %h want 00000000", bus8.d); end
        checks++; if ({bus8.bo, bus8.ov, bus8.z} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {bus8.bo, bus8.ov, bus8.z}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat;
        op8(32'd5, 32'd3, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h0000_0002, 3'b000}) begin fails++; $display("FAIL basic_result: got %h/%b want 00000002/000", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
    endtask

    task automatic test_borrow_ripple;
        int lat;
        op8(32'd0, 32'd1, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL ripple_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'hFFFF_FFFF, 3'b100}) begin fails++; $display("FAIL ripple_result: got %h/%b want ffffffff/100", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
    endtask

    task automatic test_overflow;
        int lat;
        op8(32'h8000_0000, 32'd1, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL ovf_neg_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h7FFF_FFFF, 3'b010}) begin fails++; $display("FAIL ovf_neg_result: got %h/%b want 7fffffff/010", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
        op8(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL ovf_pos_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h8000_0000, 3'b110}) begin fails++; $display("FAIL ovf_pos_result: got %h/%b want 80000000/110", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
    endtask

    task automatic test_zero;
        int lat;
        op8(32'h10, 32'h0F, 1'b1, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL zero_bi_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h0, 3'b001}) begin fails++; $display("FAIL zero_bi_result: got %h/%b want 00000000/001", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
        op8(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL zero_eq_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h0, 3'b001}) begin fails++; $display("FAIL zero_eq_result: got %h/%b want 00000000/001", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
    endtask

    task automatic test_backpressure;
        int lat;
        op8(32'd100, 32'd58, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL bp_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h0000_002A, 3'b000}) begin fails++; $display("FAIL bp_result: got %h/%b want 0000002a/000", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin bus8.a = 32'd1; bus8.b = 32'd1; bus8.bi = 1'b0; bus8.in_valid = 1'b1; end
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            checks++; if (bus8.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus8.out_valid); end
            checks++; if (bus8.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, bus8.in_ready); end
            checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h0000_002A, 3'b000}) begin fails++; $display("FAIL bp_hold_result[%0d]: got %h/%b want 0000002a/000", i, bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        end
        release8();
        checks++; if (bus8.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", bus8.out_valid); end
        checks++; if (bus8.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", bus8.in_ready); end
        op8(32'd7, 32'd2, 1'b0, lat);
        checks++; if (lat !== 4) begin fails++; $display("FAIL bp_next_latency: got %0d want 4", lat); end
        checks++; if ({bus8.d, bus8.bo, bus8.ov, bus8.z} !== {32'h0000_0005, 3'b000}) begin fails++; $display("FAIL bp_next_result: got %h/%b want 00000005/000", bus8.d, {bus8.bo, bus8.ov, bus8.z}); end
        release8();
    endtask

    task automatic test_reset_mid_run;
        int seen;
        bus8.a = 32'd0; bus8.b = 32'd1; bus8.bi = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus8.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b want 0", bus8.out_valid); end
        checks++; if (bus8.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b want 1", bus8.in_ready); end
        checks++; if (bus8.d !== 32'h0) begin fails++; $display("FAIL midrst_d: got %h want 00000000", bus8.d); end
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus8.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_k32;
        int lat;
        bus32.a = 32'd0; bus32.b = 32'd1; bus32.bi = 1'b0; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.b = 32'h0;
        lat = 0;
        while (!bus32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 1) begin fails++; $display("FAIL k32_latency: got %0d want 1", lat); end
        checks++; if ({bus32.d, bus32.bo, bus32.ov, bus32.z} !== {32'hFFFF_FFFF, 3'b100}) begin fails++; $display("FAIL k32_result: got %h/%b want ffffffff/100", bus32.d, {bus32.bo, bus32.ov, bus32.z}); end
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
    endtask

    task automatic test_k1;
        int lat;
        bus1.a = 32'd0; bus1.b = 32'd1; bus1.bi = 1'b0; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0; bus1.b = 32'h0;
        lat = 0;
        while (!bus1.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 32) begin fails++; $display("FAIL k1_latency: got %0d want 32", lat); end
        checks++; if ({bus1.d, bus1.bo, bus1.ov, bus1.z} !== {32'hFFFF_FFFF, 3'b100}) begin fails++; $display("FAIL k1_result: got %h/%b want ffffffff/100", bus1.d, {bus1.bo, bus1.ov, bus1.z}); end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.bi  = 1'b0; bus8.out_ready  = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.bi = 1'b0; bus32.out_ready = 1'b0;
        bus1.in_valid  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.bi  = 1'b0; bus1.out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_overflow();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        test_k32();
        test_k1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
